cache_dfp_arbiter: RTL and testbench

- Shares the single 256-bit line-granular memory port between the instruction-cache and data-cache dfp interfaces.
- Latches one requester's read or write, drives registered memory-side outputs, and routes the memory response back to the granted cache only.
- Uses round-robin arbitration plus a post-response gap, because caches react to dfp_resp one cycle late (registered resp) and may leave read/write high for one extra cycle.

---
 rtl/cache_types.sv | 29 ++
 rtl/cache_dfp_arbiter.sv | 141 ++++++++++++++
 tb/tb_cache_dfp_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// -----------------------------------------------------------------------------
// cache_types
// Shared types for the cache / memory-port glue.
//   arb_state_t : arbiter FSM state
//   port_sel_t  : which cache a grant or priority refers to
//   LINE_W      : cache line width in bits
//   is_req      : a cache port is requesting when read or write is high
// -----------------------------------------------------------------------------
package cache_types;

   localparam int LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      GAP     = 2'd3
   } arb_state_t;

   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } port_sel_t;

   function automatic logic is_req(input logic read, input logic write);
      return read | write;
   endfunction

endpackage

// File: rtl/cache_dfp_arbiter.sv
// -----------------------------------------------------------------------------
// cache_dfp_arbiter
// Shares one line-granular memory port between the icache and dcache dfp
// interfaces. One request is latched into registered mem_* outputs, the memory
// response is routed back only to the granted cache, and after every completed
// transaction the arbiter waits GAP_CYCLES cycles so the caches (which see
// dfp_resp one cycle late and may keep read/write high one extra cycle) cannot
// cause a duplicate request. Grants alternate round-robin, dcache first.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   i_dfp_addr/read/write/wdata     icache request
//   i_dfp_rdata, i_dfp_resp         icache response
//   d_dfp_addr/read/write/wdata     dcache request
//   d_dfp_rdata, d_dfp_resp         dcache response
//   mem_addr/read/write/wdata       registered memory request
//   mem_rdata, mem_resp             memory response (mem_resp is a 1-cycle pulse)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transaction; grant a requester on the next edge
// GRANT_I | icache transaction outstanding, waiting for mem_resp
// GRANT_D | dcache transaction outstanding, waiting for mem_resp
// GAP     | post-response quiet time, requests ignored, gap_cnt counts down
// -----------------------------------------------------------------------------
module cache_dfp_arbiter
   import cache_types::*;
#(
   parameter int GAP_CYCLES = 1,
   parameter int LINE_W     = cache_types::LINE_W
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [31:0]       i_dfp_addr,
   input  logic              i_dfp_read,
   input  logic              i_dfp_write,
   input  logic [LINE_W-1:0] i_dfp_wdata,
   output logic [LINE_W-1:0] i_dfp_rdata,
   output logic              i_dfp_resp,

   input  logic [31:0]       d_dfp_addr,
   input  logic              d_dfp_read,
   input  logic              d_dfp_write,
   input  logic [LINE_W-1:0] d_dfp_wdata,
   output logic [LINE_W-1:0] d_dfp_rdata,
   output logic              d_dfp_resp,

   output logic [31:0]       mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   // Counter loads GAP_CYCLES-1 and the exit happens on the cycle it reads 0,
   // so the FSM spends exactly GAP_CYCLES cycles in GAP.
   localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES - 1);

   arb_state_t  state;
   port_sel_t   prio;
   logic [2:0]  gap_cnt;

   logic        i_req;
   logic        d_req;
   logic        grant_i;
   logic        grant_d;

   logic [31:0]       sel_addr;
   logic [LINE_W-1:0] sel_wdata;
   logic              sel_read;
   logic              sel_write;

   assign i_req = is_req(i_dfp_read, i_dfp_write);
   assign d_req = is_req(d_dfp_read, d_dfp_write);

   assign grant_i = (state == IDLE) && i_req && (!d_req || (prio == SEL_I));
   assign grant_d = (state == IDLE) && d_req && !grant_i;

   always_comb begin
      sel_addr  = d_dfp_addr;
      sel_wdata = d_dfp_wdata;
      sel_read  = d_dfp_read;
      sel_write = d_dfp_write;
      if (grant_i) begin
         sel_addr  = i_dfp_addr;
         sel_wdata = i_dfp_wdata;
         sel_read  = i_dfp_read;
         sel_write = i_dfp_write;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prio      <= SEL_D;
         gap_cnt   <= 3'd0;
         mem_addr  <= 32'd0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_wdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_i || grant_d) begin
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  // read+write together is a write; never drive both to memory
                  mem_write <= sel_write;
                  mem_read  <= sel_read & ~sel_write;
                  state     <= grant_i ? GRANT_I : GRANT_D;
               end
            end
            GRANT_I, GRANT_D: begin
               if (mem_resp) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  prio      <= (state == GRANT_I) ? SEL_D : SEL_I;
                  gap_cnt   <= GAP_LOAD;
                  state     <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == 3'd0) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign i_dfp_resp  = mem_resp && (state == GRANT_I);
   assign d_dfp_resp  = mem_resp && (state == GRANT_D);
   assign i_dfp_rdata = mem_rdata;
   assign d_dfp_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_dfp_arbiter.sv
module tb_cache_dfp_arbiter;

   localparam int GAP_CYCLES = 1;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   i_dfp_addr, d_dfp_addr;
   logic          i_dfp_read, i_dfp_write, d_dfp_read, d_dfp_write;
   logic [LW-1:0] i_dfp_wdata, d_dfp_wdata;
   logic [LW-1:0] i_dfp_rdata, d_dfp_rdata;
   logic          i_dfp_resp, d_dfp_resp;
   logic [31:0]   mem_addr;
   logic          mem_read, mem_write;
   logic [LW-1:0] mem_wdata, mem_rdata;
   logic          mem_resp;

   always #5 clk = ~clk;

   cache_dfp_arbiter #(.GAP_CYCLES(GAP_CYCLES), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read), .i_dfp_write(i_dfp_write),
      .i_dfp_wdata(i_dfp_wdata), .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
      .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
      .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   int nvec = 0;
   int nerr = 0;

   // Reference model: who owns the memory port (0 none, 1 icache, 2 dcache),
   // who wins the next tie, the first cycle a new grant may be sampled, and
   // the request that was captured at grant time.
   int            cyc = 0;
   bit            started = 0;
   int            m_owner;
   int            m_prio;
   int            m_elig;
   logic [31:0]   m_addr;
   logic          m_read, m_write;
   logic [LW-1:0] m_wdata;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fail_timeout(input string tag);
      nvec++;
      nerr++;
      $error("FAIL %s observed=timeout expected=grant", tag);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int k = 0; k < LW/32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check_outputs();
      chk("mem_addr",  LW'(mem_addr),  LW'(m_addr));
      chk("mem_read",  LW'(mem_read),  LW'(m_read));
      chk("mem_write", LW'(mem_write), LW'(m_write));
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("i_resp", LW'(i_dfp_resp), LW'(mem_resp && m_owner == 1));
      chk("d_resp", LW'(d_dfp_resp), LW'(mem_resp && m_owner == 2));
      chk("i_rdata", i_dfp_rdata, mem_rdata);
      chk("d_rdata", d_dfp_rdata, mem_rdata);
   endtask

   task automatic model_edge();
      bit ir, dr;
      int pick;
      ir = i_dfp_read || i_dfp_write;
      dr = d_dfp_read || d_dfp_write;
      if (rst) begin
         started = 1;
         m_owner = 0; m_prio = 2; m_elig = cyc + 1;
         m_addr = '0; m_read = 0; m_write = 0; m_wdata = '0;
      end else if (started) begin
         if (m_owner != 0) begin
            if (mem_resp) begin
               m_prio  = (m_owner == 1) ? 2 : 1;
               m_owner = 0;
               m_read  = 0;
               m_write = 0;
               // GAP_CYCLES quiet cycles, then one idle cycle that samples requests
               m_elig  = cyc + GAP_CYCLES + 1;
            end
         end else if (cyc >= m_elig) begin
            pick = 0;
            if (ir && dr) pick = m_prio;
            else if (ir) pick = 1;
            else if (dr) pick = 2;
            if (pick == 1) begin
               m_addr = i_dfp_addr; m_wdata = i_dfp_wdata;
               m_write = i_dfp_write; m_read = i_dfp_read && !i_dfp_write;
            end else if (pick == 2) begin
               m_addr = d_dfp_addr; m_wdata = d_dfp_wdata;
               m_write = d_dfp_write; m_read = d_dfp_read && !d_dfp_write;
            end
            m_owner = pick;
         end
      end
      cyc++;
   endtask

   task automatic cycle();
      @(negedge clk);
      if (started) check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wait_grant(output int waited, output bit ok);
      waited = 0;
      while (!(mem_read || mem_write) && waited < 30) begin
         cycle();
         waited++;
      end
      ok = mem_read || mem_write;
   endtask

   task automatic clear_reqs();
      i_dfp_read = 0; i_dfp_write = 0; d_dfp_read = 0; d_dfp_write = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   task automatic respond(input logic [LW-1:0] data);
      mem_resp = 1; mem_rdata = data;
      cycle();
      mem_resp = 0;
   endtask

   initial begin
      int w;
      bit ok;
      int who;
      logic [LW-1:0] a5, dead;
      a5   = {32{8'hA5}};
      dead = {8{32'hDEADBEEF}};

      rst = 1; clear_reqs();
      i_dfp_addr = '0; d_dfp_addr = '0; i_dfp_wdata = '0; d_dfp_wdata = '0;
      mem_rdata = '0; mem_resp = 0;
      cycle();
      do_reset();

      // icache read: grant latency and response routing
      i_dfp_read = 1; i_dfp_addr = 32'h0000_1000;
      cycle();
      chk("t1_mem_read", LW'(mem_read), LW'(1'b1));
      chk("t1_mem_addr", LW'(mem_addr), LW'(32'h1000));
      repeat (4) cycle();
      mem_resp = 1; mem_rdata = a5; #1;
      chk("t1_i_resp", LW'(i_dfp_resp), LW'(1'b1));
      chk("t1_i_rdata", i_dfp_rdata, a5);
      chk("t1_d_resp", LW'(d_dfp_resp), LW'(1'b0));
      cycle();
      mem_resp = 0;
      chk("t1_read_cleared", LW'(mem_read), LW'(1'b0));
      cycle();
      clear_reqs();
      repeat (3) cycle();

      // simultaneous requests after reset: dcache first, then icache
      do_reset();
      i_dfp_read = 1; i_dfp_addr = 32'h100;
      d_dfp_write = 1; d_dfp_addr = 32'h200; d_dfp_wdata = dead;
      cycle();
      chk("t2_d_write", LW'(mem_write), LW'(1'b1));
      chk("t2_d_addr", LW'(mem_addr), LW'(32'h200));
      chk("t2_d_wdata", mem_wdata, dead);
      repeat (2) cycle();
      respond(rand_line());
      wait_grant(w, ok);
      if (!ok) fail_timeout("t2_grant_i");
      chk("t2_i_read", LW'(mem_read), LW'(1'b1));
      chk("t2_i_addr", LW'(mem_addr), LW'(32'h100));
      chk("t2_i_gap", LW'(w), LW'(GAP_CYCLES + 1));
      cycle();
      respond(rand_line());

      // both held: strict alternation D,I,D,I,D,I with a fixed quiet gap
      for (int t = 0; t < 6; t++) begin
         wait_grant(w, ok);
         if (!ok) fail_timeout("t3_grant");
         who = (mem_addr == 32'h200) ? 2 : 1;
         chk("t3_order", LW'(who), LW'((t % 2 == 0) ? 2 : 1));
         chk("t3_gap", LW'(w), LW'(GAP_CYCLES + 1));
         repeat (2) cycle();
         respond(rand_line());
      end
      clear_reqs();
      repeat (4) cycle();

      // dcache read held one cycle past its resp, plus spurious resp in GAP
      do_reset();
      d_dfp_read = 1; d_dfp_addr = 32'h300;
      repeat (2) cycle();
      respond(a5);
      mem_resp = 1; #1;
      chk("t5_gap_i_resp", LW'(i_dfp_resp), LW'(1'b0));
      chk("t5_gap_d_resp", LW'(d_dfp_resp), LW'(1'b0));
      cycle();
      mem_resp = 0;
      d_dfp_read = 0;
      repeat (4) cycle();
      chk("t4_no_dup", LW'(mem_read), LW'(1'b0));

      // spurious resp in IDLE
      mem_resp = 1; #1;
      chk("t5_idle_i_resp", LW'(i_dfp_resp), LW'(1'b0));
      chk("t5_idle_d_resp", LW'(d_dfp_resp), LW'(1'b0));
      cycle();
      mem_resp = 0;
      i_dfp_read = 1; i_dfp_addr = 32'h340;
      cycle();
      chk("t5_after_idle", LW'(mem_read), LW'(1'b1));
      respond(rand_line());
      clear_reqs();
      repeat (3) cycle();

      // reset while dcache write outstanding
      d_dfp_write = 1; d_dfp_addr = 32'h400; d_dfp_wdata = dead;
      cycle();
      chk("t6_write", LW'(mem_write), LW'(1'b1));
      do_reset();
      clear_reqs();
      chk("t6_rst_write", LW'(mem_write), LW'(1'b0));
      chk("t6_rst_addr", LW'(mem_addr), LW'(32'h0));
      chk("t6_rst_wdata", mem_wdata, '0);
      mem_resp = 1; #1;
      chk("t6_late_d_resp", LW'(d_dfp_resp), LW'(1'b0));
      cycle();
      mem_resp = 0;
      i_dfp_read = 1; i_dfp_addr = 32'h500;
      d_dfp_read = 1; d_dfp_addr = 32'h600;
      cycle();
      chk("t6_prio_d", LW'(mem_addr), LW'(32'h600));
      respond(rand_line());
      clear_reqs();
      repeat (3) cycle();

      // randomized traffic, spurious responses and occasional resets
      for (int n = 0; n < 1500; n++) begin
         rst         = ($urandom_range(0, 99) == 0);
         i_dfp_read  = $urandom_range(0, 1);
         i_dfp_write = ($urandom_range(0, 3) == 0);
         d_dfp_read  = $urandom_range(0, 1);
         d_dfp_write = $urandom_range(0, 1);
         i_dfp_addr  = $urandom & 32'hFFFF_FFE0;
         d_dfp_addr  = $urandom & 32'hFFFF_FFE0;
         i_dfp_wdata = rand_line();
         d_dfp_wdata = rand_line();
         mem_rdata   = rand_line();
         mem_resp    = ($urandom_range(0, 3) == 0);
         cycle();
      end
      rst = 0; mem_resp = 0; clear_reqs();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
